pong_tile_scanner: RTL and testbench

PONG_TILE_SCANNER -- requirements
Module: pong_tile_scanner

---
 rtl/pong_tile_scanner.sv | 124 ++++++++++++
 tb/tb_pong_tile_scanner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_tile_scanner.sv
// VGA raster scanner for a tile-based Pong: generates the game-grid coordinate of
// the current pixel and turns the objects' registered draw flag into sync-aligned RGB.
module pong_tile_scanner #(
    parameter int         H_ACTIVE   = 640,
    parameter int         H_TOTAL    = 800,
    parameter int         H_FRONT    = 16,
    parameter int         H_SYNC     = 96,
    parameter int         V_ACTIVE   = 480,
    parameter int         V_TOTAL    = 525,
    parameter int         V_FRONT    = 10,
    parameter int         V_SYNC     = 2,
    parameter int         TILE_SHIFT = 4,
    parameter logic [8:0] FG_COLOR   = 9'h1FF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_draw,
    output logic [5:0] o_col,
    output logic [5:0] o_row,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic [2:0] o_red,
    output logic [2:0] o_green,
    output logic [2:0] o_blue,
    output logic       o_frame_start
);

    localparam logic [9:0] H_ACT_END    = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    // Stage 0: raster counters
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    // Stage 1: raster attributes, aligned with the objects' registered i_draw
    logic       r_s1_active;
    logic       r_s1_hsync;
    logic       r_s1_vsync;

    // Stage 2: pin registers
    logic [8:0] r_rgb;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_frame_start;

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_active;
    logic       w_hsync_raw;
    logic       w_vsync_raw;
    logic [5:0] w_col;
    logic [5:0] w_row;
    logic [8:0] w_rgb_next;

    assign w_h_wrap    = (r_h_cnt == H_LAST);
    assign w_v_wrap    = (r_v_cnt == V_LAST);
    assign w_active    = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
    assign w_hsync_raw = !((r_h_cnt >= H_SYNC_START) && (r_h_cnt < H_SYNC_END));
    assign w_vsync_raw = !((r_v_cnt >= V_SYNC_START) && (r_v_cnt < V_SYNC_END));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values and simulation matches the synthesized netlist.
            r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 10'd1;
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 10'd1;
            end
        end
    end

    // 6'h3F during blanking guarantees no object can match a blank pixel.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        w_col = 6'h3F;
        w_row = 6'h3F;
        if (w_active) begin
            w_col = 6'(r_h_cnt >> TILE_SHIFT);
            w_row = 6'(r_v_cnt >> TILE_SHIFT);
        end
    end

    assign w_rgb_next = (r_s1_active && i_draw) ? FG_COLOR : 9'd0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_active   <= 1'b0;
            r_s1_hsync    <= 1'b1;
            r_s1_vsync    <= 1'b1;
            r_rgb         <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_s1_active   <= w_active;
            r_s1_hsync    <= w_hsync_raw;
            r_s1_vsync    <= w_vsync_raw;
            r_rgb         <= w_rgb_next;
            r_hsync       <= r_s1_hsync;
            r_vsync       <= r_s1_vsync;
            r_frame_start <= w_h_wrap && w_v_wrap;
        end
    end

    assign o_col         = w_col;
    assign o_row         = w_row;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_red         = r_rgb[8:6];
    assign o_green       = r_rgb[5:3];
    assign o_blue        = r_rgb[2:0];
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_pong_tile_scanner.sv
// Scoreboard bench for pong_tile_scanner: a shrunken raster for whole-frame checks
// plus a default-timing instance for the first lines of the standard 640x480 mode.
module tb_pong_tile_scanner;

    localparam int HA = 64, HF = 4, HS = 8, HT = 96;
    localparam int VA = 48, VF = 2, VS = 2, VT = 56;
    localparam int TS = 4;
    localparam int FRAME = HT * VT;
    localparam logic [8:0] FG = 9'h1A5;
    localparam logic [5:0] PAD_COL = 6'd0;
    localparam logic [5:0] PAD_ROW_LO = 6'd1;
    localparam logic [5:0] PAD_ROW_HI = 6'd2;

    typedef enum logic [1:0] {MODE_OFF, MODE_ALL, MODE_PADDLE} mode_t;
    typedef struct packed {
        logic [8:0] rgb;
        logic       hs;
        logic       vs;
    } pin_t;
    localparam pin_t PIN_RST = '{rgb: 9'd0, hs: 1'b1, vs: 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic draw = 1'b0;
    logic draw_def = 1'b1;
    mode_t mode = MODE_OFF;

    logic [5:0] o_col, o_row, o_col_d, o_row_d;
    logic       o_hsync, o_vsync, o_hsync_d, o_vsync_d;
    logic [2:0] o_red, o_green, o_blue, o_red_d, o_green_d, o_blue_d;
    logic       o_frame_start, o_frame_start_d;

    pong_tile_scanner #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_FRONT(HF), .H_SYNC(HS),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_FRONT(VF), .V_SYNC(VS),
        .TILE_SHIFT(TS), .FG_COLOR(FG)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_draw(draw),
        .o_col(o_col), .o_row(o_row), .o_hsync(o_hsync), .o_vsync(o_vsync),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_frame_start(o_frame_start)
    );

    pong_tile_scanner dut_def (
        .i_clk(clk), .i_reset(rst), .i_draw(draw_def),
        .o_col(o_col_d), .o_row(o_row_d), .o_hsync(o_hsync_d), .o_vsync(o_vsync_d),
        .o_red(o_red_d), .o_green(o_green_d), .o_blue(o_blue_d),
        .o_frame_start(o_frame_start_d)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Game objects: register their hit flag one clock after o_col/o_row.
    always @(posedge clk) begin
        case (mode)
            MODE_ALL:    draw <= 1'b1;
            MODE_PADDLE: draw <= (o_col == PAD_COL) && (o_row >= PAD_ROW_LO) && (o_row <= PAD_ROW_HI);
            default:     draw <= 1'b0;
        endcase
    end

    function automatic pin_t expect_pins(input int h, input int v, input mode_t md);
        pin_t p;
        logic active, on;
        active = (h < HA) && (v < VA);
        on = active && ((md == MODE_ALL) ||
             ((md == MODE_PADDLE) && ((h >> TS) == 0) && ((v >> TS) >= 1) && ((v >> TS) <= 2)));
        p.rgb = on ? FG : 9'd0;
        p.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        p.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        return p;
    endfunction

    function automatic logic [11:0] expect_colrow(input int h, input int v);
        if ((h < HA) && (v < VA)) return {6'(h >> TS), 6'(v >> TS)};
        return 12'hFFF;
    endfunction

    // Reference raster: pushes the expected pin values two clocks ahead of the pins.
    int   m_h = 0, m_v = 0, def_cyc = 0;
    logic exp_fs = 1'b0;
    pin_t exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_q.push_back(PIN_RST);
            exp_q.push_back(PIN_RST);
            m_h = 0;
            m_v = 0;
            exp_fs = 1'b0;
            def_cyc = 0;
        end else begin
            exp_q.push_back(expect_pins(m_h, m_v, mode));
            exp_fs = (m_h == HT - 1) && (m_v == VT - 1);
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
            def_cyc = def_cyc + 1;
        end
    end

    int   hs_run = 0, vs_low = 0, rgb_on = 0, frame_len = 0;
    logic have_prev_fs = 1'b0, all_ok = 1'b1, pad_ok = 1'b1;
    int   d_hs_run = 0;
    logic d_prev_hs = 1'b1, d_seen_fall = 1'b0;

    always @(negedge clk) begin
        pin_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rgb", {o_red, o_green, o_blue}, e.rgb);
            check("hsync_vsync", {o_hsync, o_vsync}, {e.hs, e.vs});
            check("col_row", {o_col, o_row}, expect_colrow(m_h, m_v));
            check("frame_start", o_frame_start, exp_fs);
        end

        if (rst) begin
            hs_run = 0; vs_low = 0; rgb_on = 0; frame_len = 0;
            have_prev_fs = 1'b0; all_ok = 1'b1; pad_ok = 1'b1;
        end else begin
            if (!o_hsync) hs_run++;
            else if (hs_run > 0) begin
                check("hsync_width", hs_run, HS);
                hs_run = 0;
            end
            if (!o_vsync) vs_low++;
            if ({o_red, o_green, o_blue} != 9'd0) rgb_on++;
            frame_len++;
            if (o_frame_start) begin
                check("vsync_low_clocks", vs_low, VS * HT);
                if (all_ok) check("all_draw_pixels", rgb_on, HA * VA);
                if (pad_ok) check("paddle_pixels", rgb_on, 16 * 32);
                if (have_prev_fs) check("frame_period", frame_len, FRAME);
                vs_low = 0; rgb_on = 0; frame_len = 0;
                have_prev_fs = 1'b1; all_ok = 1'b1; pad_ok = 1'b1;
            end
            all_ok = all_ok && (mode == MODE_ALL);
            pad_ok = pad_ok && (mode == MODE_PADDLE);
        end

        // Default 640x480 timing, first lines after each reset release.
        if (rst) begin
            d_hs_run = 0; d_prev_hs = 1'b1; d_seen_fall = 1'b0;
        end else if (def_cyc < 2400) begin
            if (def_cyc == 2)   check("def_rgb_first_pixel", {o_red_d, o_green_d, o_blue_d}, 9'h1FF);
            if (def_cyc == 642) check("def_rgb_hblank", {o_red_d, o_green_d, o_blue_d}, 9'h000);
            if (def_cyc == 639) check("def_colrow_h639", {o_col_d, o_row_d}, {6'd39, 6'd0});
            if (def_cyc == 640) check("def_colrow_h640", {o_col_d, o_row_d}, {6'h3F, 6'h3F});
            if (!o_hsync_d) d_hs_run++;
            else if (d_hs_run > 0) begin
                check("def_hsync_width", d_hs_run, 96);
                d_hs_run = 0;
            end
            if (d_prev_hs && !o_hsync_d && !d_seen_fall) begin
                check("def_hsync_first_fall", def_cyc, 658);
                d_seen_fall = 1'b1;
            end
            d_prev_hs = o_hsync_d;
        end
    end

    task automatic wait_fs(input string tag, input int bound);
        logic found;
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (o_frame_start) found = 1'b1;
        end
        check(tag, found, 1'b1);
    endtask

    initial begin
        logic hit;
        rst = 1'b1;
        mode = MODE_OFF;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_rgb", {o_red, o_green, o_blue}, 9'd0);
        check("rst_syncs", {o_hsync, o_vsync, o_hsync_d, o_vsync_d}, 4'hF);
        check("rst_frame_start", {o_frame_start, o_frame_start_d}, 2'b00);
        check("rst_colrow", {o_col, o_row}, 12'd0);

        // Frame 1: every object drawing
        @(posedge clk); #1;
        rst = 1'b0;
        mode = MODE_ALL;
        wait_fs("first_frame_start_seen", FRAME + 16);
        check("first_frame_start_clocks", def_cyc, FRAME);

        // Frame 2: paddle only
        @(posedge clk); #1;
        mode = MODE_PADDLE;
        wait_fs("second_frame_start_seen", FRAME + 16);

        // Abandon frame 3 mid-way
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            @(posedge clk); #1;
            if (m_h == 30 && m_v == 20) hit = 1'b1;
        end
        check("midframe_point_reached", hit, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_rgb", {o_red, o_green, o_blue}, 9'd0);
        check("midrst_syncs", {o_hsync, o_vsync}, 2'b11);
        check("midrst_frame_start", o_frame_start, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("restart_colrow", {o_col, o_row}, 12'd0);
        wait_fs("restart_frame_start_seen", FRAME + 16);
        check("restart_frame_start_clocks", def_cyc, FRAME);

        repeat (10) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
